// File: rtl/rr_arb_pkg.sv
// Shared definitions for the round-robin grant arbiter: FSM states,
// default index width and a one-hot decode helper.
package rr_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    localparam int unsigned MAX_N = 32;
    localparam int unsigned DEF_N = 4;
    localparam int unsigned ARB_W = $clog2(DEF_N);

    function automatic logic [MAX_N-1:0] onehot(input int unsigned idx, input int unsigned n);
        logic [MAX_N-1:0] r;
        r = '0;
        if (idx < n && idx < MAX_N) r[idx] = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/prio_enc_hi.sv
// Highest-index-wins priority encoder; idx is 0 when nothing is set.
module prio_enc_hi #(
    parameter  int N = 4,
    localparam int W = $clog2(N)
) (
    input  logic [N-1:0] v,
    output logic [W-1:0] idx,
    output logic         found
);

    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (v[i]) begin
                idx   = W'(i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_grant_arbiter.sv
// Round-robin arbiter: rotating-mask pick over highest-index-wins encoders,
// registered grant outputs, holder tenure bounded by MAX_HOLD.
module rr_grant_arbiter #(
    parameter  int N        = 4,
    parameter  int MAX_HOLD = 4,
    localparam int W        = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    output logic [N-1:0] grant,
    output logic [W-1:0] grant_idx,
    output logic         grant_valid
);
    import rr_arb_pkg::*;

    localparam int HW = $clog2(MAX_HOLD + 1);

    arb_state_e   r_state, w_state_nxt;
    logic [N-1:0] r_grant, w_grant_nxt;
    logic [W-1:0] r_grant_idx, w_grant_idx_nxt;
    logic         r_grant_valid, w_grant_valid_nxt;
    logic [W-1:0] r_last_ptr, w_last_ptr_nxt;
    logic [HW-1:0] r_hold_cnt, w_hold_cnt_nxt;

    logic [N-1:0] w_hold_oh, w_others, w_pick_v, w_lo_mask, w_masked;
    logic [W-1:0] w_m_idx, w_u_idx, w_win;
    logic         w_m_found, w_u_found, w_hold_req, w_hold_last;

    assign w_hold_oh   = N'(onehot(int'(r_grant_idx), N));
    assign w_others    = req & ~w_hold_oh;
    assign w_pick_v    = (r_state == IDLE) ? req : w_others;
    assign w_hold_req  = |(req & w_hold_oh);
    assign w_hold_last = (r_hold_cnt == HW'(MAX_HOLD - 1));

    // Only indices below the last winner get first refusal, giving the
    // descending rotation k-1, ..., 0, N-1, ..., k.
    always_comb begin
        w_lo_mask = '0;
        for (int i = 0; i < N; i++) begin
            w_lo_mask[i] = (W'(i) < r_last_ptr);
        end
    end

    assign w_masked = w_pick_v & w_lo_mask;

    prio_enc_hi #(.N(N)) u_enc_masked (
        .v     (w_masked),
        .idx   (w_m_idx),
        .found (w_m_found)
    );

    prio_enc_hi #(.N(N)) u_enc_full (
        .v     (w_pick_v),
        .idx   (w_u_idx),
        .found (w_u_found)
    );

    assign w_win = w_m_found ? w_m_idx : w_u_idx;

    always_comb begin
        w_state_nxt       = r_state;
        w_grant_nxt       = r_grant;
        w_grant_idx_nxt   = r_grant_idx;
        w_grant_valid_nxt = r_grant_valid;
        w_last_ptr_nxt    = r_last_ptr;
        w_hold_cnt_nxt    = r_hold_cnt;
        unique case (r_state)
            IDLE: begin
                if (w_u_found) begin
                    w_state_nxt       = GRANT;
                    w_grant_nxt       = N'(onehot(int'(w_win), N));
                    w_grant_idx_nxt   = w_win;
                    w_grant_valid_nxt = 1'b1;
                    w_last_ptr_nxt    = w_win;
                    w_hold_cnt_nxt    = '0;
                end
            end
            GRANT: begin
                if (w_u_found && (!w_hold_req || w_hold_last)) begin
                    w_grant_nxt       = N'(onehot(int'(w_win), N));
                    w_grant_idx_nxt   = w_win;
                    w_grant_valid_nxt = 1'b1;
                    w_last_ptr_nxt    = w_win;
                    w_hold_cnt_nxt    = '0;
                end else if (!w_hold_req) begin
                    w_state_nxt       = IDLE;
                    w_grant_nxt       = '0;
                    w_grant_idx_nxt   = '0;
                    w_grant_valid_nxt = 1'b0;
                    w_hold_cnt_nxt    = '0;
                end else if (w_hold_last) begin
                    // Nobody else is waiting, so the holder simply starts a new tenure.
                    w_hold_cnt_nxt = '0;
                end else begin
                    w_hold_cnt_nxt = r_hold_cnt + HW'(1);
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_grant       <= '0;
            r_grant_idx   <= '0;
            r_grant_valid <= 1'b0;
            r_last_ptr    <= '0;
            r_hold_cnt    <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_grant       <= w_grant_nxt;
            r_grant_idx   <= w_grant_idx_nxt;
            r_grant_valid <= w_grant_valid_nxt;
            r_last_ptr    <= w_last_ptr_nxt;
            r_hold_cnt    <= w_hold_cnt_nxt;
        end
    end

    assign grant       = r_grant;
    assign grant_idx   = r_grant_idx;
    assign grant_valid = r_grant_valid;

endmodule

// File: doc/rr_grant_arbiter.md
Name: rr_grant_arbiter

Overview:
- Round-robin arbiter that shares one resource among N requesters.
- Arbitration reuses the team's highest-index-wins priority encoding, applied to a rotating mask.
- Registered one-hot grant, binary grant index and valid flag; holder keeps the grant while requesting, bounded by MAX_HOLD.
- Sits in front of any shared datapath resource; downstream muxes steer on grant_idx.

Parameters:
- N, 4, number of requesters (N >= 2).
- W, $clog2(N), width of grant_idx (derived, not overridden).
- MAX_HOLD, 4, max consecutive grant cycles while other requesters wait (>= 1).

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  N  request vector, bit i = requester i.
- grant  output  N  one-hot grant, registered; all zero when idle.
- grant_idx  output  W  binary index of granted requester, registered; 0 when idle.
- grant_valid  output  1  high when grant is non-zero.

Behaviour:
- Reset (async assert, sync release): grant=0, grant_idx=0, grant_valid=0, state=IDLE, last_ptr=0, hold_cnt=0.
- Pick function, combinational on vector v and last_ptr k:
  - masked = v & (bits with index < k).
  - If masked != 0, winner = highest set index of masked; else winner = highest set index of v.
  - Found flag = |v.
- States IDLE and GRANT.
- IDLE:
  - If req != 0: winner = pick(req); next cycle grant=onehot(winner), grant_idx=winner, grant_valid=1, last_ptr=winner, hold_cnt=0, go GRANT.
  - Request-to-grant latency is exactly 1 clock.
  - If req == 0: stay IDLE, outputs 0.
- GRANT, holder h = grant_idx, others = req & ~onehot(h):
  - Release when req[h]==0. If others != 0, register pick(others) next cycle with no idle bubble; else go IDLE with outputs 0.
  - Preempt when req[h]==1, hold_cnt==MAX_HOLD-1 and others != 0. Register pick(others) next cycle; holder has had exactly MAX_HOLD cycles.
  - Hold when req[h]==1 and no preempt: grant unchanged. hold_cnt increments; if hold_cnt==MAX_HOLD-1 and others==0, hold_cnt wraps to 0 and the grant persists.
  - Every new grant sets last_ptr=winner and hold_cnt=0.
- Pointer rotation: after granting k, priority order is k-1, k-2, ..., 0, N-1, ..., k. This guarantees every steady requester is served within N*MAX_HOLD cycles.
- Widths: hold_cnt is $clog2(MAX_HOLD+1) bits; masked compare k < N in W bits.
- Invariants, checked every cycle: grant is one-hot or zero; grant_valid == |grant; grant == onehot(grant_idx) when valid.
- req is sampled only at clk edges; glitches between edges are ignored.
- Reset mid-grant: outputs clear immediately and asynchronously; the first arbitration after release behaves as from power-up (last_ptr=0).

Decomposition:
- Shared package rr_arb_pkg:
  - state enum {IDLE, GRANT}.
  - function onehot(idx, N).
  - constant W = $clog2(N).
- Sub-module prio_enc_hi, combinational, parameter N. Inputs v[N-1:0]; outputs idx[W-1:0] (highest set bit) and found. Instantiated twice: masked and unmasked.
- Top-level muxes the two encoder results, holds the FSM, last_ptr and hold_cnt, and registers the outputs.

Test Plan:
1. Reset: rst_n=0 with req=4'b1111 -> grant=4'b0000, grant_idx=0, grant_valid=0 throughout; asserting rst_n mid-cycle clears outputs without waiting for a clock.
2. First grant: from reset, req=4'b0101 at edge 0 -> edge 1: grant=4'b0100, grant_idx=2, grant_valid=1.
3. Handover, no bubble: while holding idx 2, req changes to 4'b0001 -> next edge grant=4'b0001, grant_idx=0; then req=0 -> next edge grant_valid=0, grant_idx=0.
4. Fairness: N=4, MAX_HOLD=4, req=4'b1111 held -> grant_idx sequence 3,3,3,3,2,2,2,2,1,1,1,1,0,0,0,0,3...
5. Lone holder: req=4'b0010 for 12 cycles -> grant=4'b0010 on every cycle after the first; no drop at hold_cnt wrap.
6. Reset mid-operation: rst_n pulsed low while grant_idx=1 with req=4'b1111 -> outputs 0 immediately; after release, first grant_idx=3.
